// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared rename-register-file sizing constants for the allocation controller and its valid array.
package rrf_alloc_ctrl_pkg;

    localparam int RRF_TAG_W = 6;
    localparam int RRF_DEPTH = 2 ** RRF_TAG_W;
    localparam int RRF_CNT_W = RRF_TAG_W + 1;

endpackage

// File: rtl/rrf_vld_array.sv
// Per-entry RRF valid flops: two writeback set ports, two allocation clear ports, clear wins.
module rrf_vld_array
    import rrf_alloc_ctrl_pkg::*;
#(
    parameter int RRF_ENT_SEL = RRF_TAG_W,
    parameter int RRF_ENT_NUM = RRF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr1_en,
    input  logic [RRF_ENT_SEL-1:0] clr1_tag,
    input  logic                   clr2_en,
    input  logic [RRF_ENT_SEL-1:0] clr2_tag,
    input  logic                   set1_en,
    input  logic [RRF_ENT_SEL-1:0] set1_tag,
    input  logic                   set2_en,
    input  logic [RRF_ENT_SEL-1:0] set2_tag,
    output logic [RRF_ENT_NUM-1:0] vld
);

    logic [RRF_ENT_NUM-1:0] set_mask;
    logic [RRF_ENT_NUM-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set1_en) set_mask[set1_tag] = 1'b1;
        if (set2_en) set_mask[set2_tag] = 1'b1;
        if (clr1_en) clr_mask[clr1_tag] = 1'b1;
        if (clr2_en) clr_mask[clr2_tag] = 1'b1;
    end

    // A freshly allocated entry is pending even if a stale writeback hits it this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= (vld | set_mask) & ~clr_mask;
        end
    end

endmodule

// File: rtl/rrf_alloc_ctrl.sv
// In-order ring allocator for the rename register file: tag hand-out, commit retire, flush rollback.
module rrf_alloc_ctrl
    import rrf_alloc_ctrl_pkg::*;
#(
    parameter int RRF_ENT_SEL = RRF_TAG_W,
    parameter int RRF_ENT_NUM = RRF_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_alloc_num,
    input  logic                   i_stall_in,
    output logic                   o_alloc_stall,
    output logic [RRF_ENT_SEL-1:0] o_rrftag1,
    output logic [RRF_ENT_SEL-1:0] o_rrftag2,
    input  logic [1:0]             i_com_num,
    input  logic                   i_wb1_en,
    input  logic                   i_wb2_en,
    input  logic [RRF_ENT_SEL-1:0] i_wb1_tag,
    input  logic [RRF_ENT_SEL-1:0] i_wb2_tag,
    input  logic                   i_flush,
    input  logic [RRF_ENT_SEL-1:0] i_flush_ptr,
    output logic [RRF_ENT_SEL:0]   o_free_cnt,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr,
    output logic [RRF_ENT_NUM-1:0] o_rrf_vld
);

    localparam int CNT_W = RRF_ENT_SEL + 1;

    logic [RRF_ENT_SEL-1:0] alloc_ptr;
    logic [RRF_ENT_SEL-1:0] com_ptr;
    logic [RRF_ENT_SEL-1:0] com_ptr_next;
    logic [RRF_ENT_SEL-1:0] flush_dist;
    logic [CNT_W-1:0]       free_cnt;
    logic [CNT_W-1:0]       free_cnt_next;
    logic [1:0]             alloc_eff;

    // Stall looks only at the registered count; commits free space one cycle later.
    assign o_alloc_stall = CNT_W'(i_alloc_num) > free_cnt;
    assign alloc_eff     = (!i_stall_in && !o_alloc_stall && !i_flush) ? i_alloc_num : 2'd0;

    assign o_rrftag1  = alloc_ptr;
    assign o_rrftag2  = alloc_ptr + RRF_ENT_SEL'(1);
    assign o_free_cnt = free_cnt;
    assign o_com_ptr  = com_ptr;

    assign com_ptr_next = com_ptr + RRF_ENT_SEL'(i_com_num);
    // Ring distance from the surviving oldest entry to the flush point is what stays in flight.
    assign flush_dist   = i_flush_ptr - com_ptr_next;

    always_comb begin
        if (i_flush) begin
            free_cnt_next = CNT_W'(RRF_ENT_NUM) - CNT_W'(flush_dist);
        end else begin
            free_cnt_next = free_cnt - CNT_W'(alloc_eff) + CNT_W'(i_com_num);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            alloc_ptr <= '0;
            com_ptr   <= '0;
            free_cnt  <= CNT_W'(RRF_ENT_NUM);
        end else begin
            alloc_ptr <= i_flush ? i_flush_ptr : alloc_ptr + RRF_ENT_SEL'(alloc_eff);
            com_ptr   <= com_ptr_next;
            free_cnt  <= free_cnt_next;
        end
    end

    rrf_vld_array #(
        .RRF_ENT_SEL (RRF_ENT_SEL),
        .RRF_ENT_NUM (RRF_ENT_NUM)
    ) u_vld (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr1_en  (alloc_eff != 2'd0),
        .clr1_tag (o_rrftag1),
        .clr2_en  (alloc_eff == 2'd2),
        .clr2_tag (o_rrftag2),
        .set1_en  (i_wb1_en),
        .set1_tag (i_wb1_tag),
        .set2_en  (i_wb2_en),
        .set2_tag (i_wb2_tag),
        .vld      (o_rrf_vld)
    );

    a_alloc_num_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        i_alloc_num != 2'd3);
    a_com_within_alloc: assert property (@(posedge i_clk) disable iff (i_rst)
        CNT_W'(i_com_num) <= CNT_W'(RRF_ENT_NUM) - free_cnt);
    a_flush_not_empty_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_flush && free_cnt == '0 && i_flush_ptr == alloc_ptr));

endmodule

// File: tb/tb_rrf_alloc_ctrl.sv
// Directed bench for rrf_alloc_ctrl with a ring-occupancy reference model checked every cycle.
module tb_rrf_alloc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_num;
    logic        stall_in;
    logic        alloc_stall;
    logic [5:0]  rrftag1;
    logic [5:0]  rrftag2;
    logic [1:0]  com_num;
    logic        wb1_en;
    logic        wb2_en;
    logic [5:0]  wb1_tag;
    logic [5:0]  wb2_tag;
    logic        flush;
    logic [5:0]  flush_ptr;
    logic [6:0]  free_cnt;
    logic [5:0]  com_ptr;
    logic [63:0] rrf_vld;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rrf_alloc_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alloc_num   (alloc_num),
        .i_stall_in    (stall_in),
        .o_alloc_stall (alloc_stall),
        .o_rrftag1     (rrftag1),
        .o_rrftag2     (rrftag2),
        .i_com_num     (com_num),
        .i_wb1_en      (wb1_en),
        .i_wb2_en      (wb2_en),
        .i_wb1_tag     (wb1_tag),
        .i_wb2_tag     (wb2_tag),
        .i_flush       (flush),
        .i_flush_ptr   (flush_ptr),
        .o_free_cnt    (free_cnt),
        .o_com_ptr     (com_ptr),
        .o_rrf_vld     (rrf_vld)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: ring of in-flight entries described by oldest pointer, next pointer and occupancy.
    int          m_aptr;
    int          m_cptr;
    int          m_used;
    logic [63:0] m_vld;

    always @(negedge clk) begin
        int m_free;
        int eff;
        int cnext;
        if (rst) begin
            m_aptr = 0;
            m_cptr = 0;
            m_used = 0;
            m_vld  = '0;
        end else begin
            m_free = 64 - m_used;
            chk("model_tag1", rrftag1, m_aptr);
            chk("model_tag2", rrftag2, (m_aptr + 1) % 64);
            chk("model_stall", alloc_stall, int'(alloc_num) > m_free);
            chk("model_free_cnt", free_cnt, m_free);
            chk("model_com_ptr", com_ptr, m_cptr);
            chk("model_vld", rrf_vld, m_vld);
            eff   = (!stall_in && int'(alloc_num) <= m_free && !flush) ? int'(alloc_num) : 0;
            cnext = (m_cptr + int'(com_num)) % 64;
            if (wb1_en) m_vld[wb1_tag] = 1'b1;
            if (wb2_en) m_vld[wb2_tag] = 1'b1;
            for (int k = 0; k < eff; k++) m_vld[(m_aptr + k) % 64] = 1'b0;
            if (flush) begin
                m_used = (int'(flush_ptr) - cnext + 64) % 64;
                m_aptr = int'(flush_ptr);
            end else begin
                m_used = m_used + eff - int'(com_num);
                m_aptr = (m_aptr + eff) % 64;
            end
            m_cptr = cnext;
        end
    end

    task automatic cyc(input logic [1:0] an, input logic si, input logic [1:0] cn,
                       input logic w1e, input logic [5:0] w1t,
                       input logic w2e, input logic [5:0] w2t,
                       input logic fl, input logic [5:0] fp);
        @(posedge clk);
        #1;
        alloc_num = an;
        stall_in  = si;
        com_num   = cn;
        wb1_en    = w1e;
        wb1_tag   = w1t;
        wb2_en    = w2e;
        wb2_tag   = w2t;
        flush     = fl;
        flush_ptr = fp;
        #1;
    endtask

    task automatic cyc_a(input logic [1:0] an, input logic [1:0] cn);
        cyc(an, 1'b0, cn, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
    endtask

    task automatic cyc_f(input logic [5:0] fp, input logic [1:0] an, input logic [1:0] cn);
        cyc(an, 1'b0, cn, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, fp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        alloc_num = 2'd0; stall_in = 1'b0; com_num = 2'd0;
        wb1_en = 1'b0; wb1_tag = 6'd0; wb2_en = 1'b0; wb2_tag = 6'd0;
        flush = 1'b0; flush_ptr = 6'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_tag1", rrftag1, 0);
        chk("reset_free", free_cnt, 64);
        chk("reset_vld", rrf_vld, 0);
        chk("reset_com_ptr", com_ptr, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill the ring two tags at a time.
        for (int i = 0; i < 32; i++) begin
            cyc_a(2'd2, 2'd0);
            chk("fill_tag1", rrftag1, 2 * i);
            chk("fill_tag2", rrftag2, 2 * i + 1);
        end
        cyc_a(2'd1, 2'd0);
        chk("full_free", free_cnt, 0);
        chk("full_stall", alloc_stall, 1);
        chk("full_tag1", rrftag1, 0);

        // Same-cycle commit does not relieve the stall.
        cyc_a(2'd1, 2'd2);
        chk("full_com_stall", alloc_stall, 1);
        cyc_a(2'd1, 2'd0);
        chk("after_com_free", free_cnt, 2);
        chk("after_com_ptr", com_ptr, 2);
        chk("after_com_stall", alloc_stall, 0);
        chk("after_com_tag1", rrftag1, 0);
        cyc_a(2'd0, 2'd0);
        chk("alloc0_tag1", rrftag1, 1);
        chk("alloc0_free", free_cnt, 1);

        // Retire 7, then flush to 63 leaving ten free entries.
        cyc_a(2'd0, 2'd2);
        cyc_a(2'd0, 2'd2);
        cyc_a(2'd0, 2'd2);
        cyc_a(2'd0, 2'd1);
        cyc_f(6'd63, 2'd0, 2'd0);
        cyc_a(2'd2, 2'd0);
        chk("wrap_tag1", rrftag1, 63);
        chk("wrap_tag2", rrftag2, 0);
        chk("wrap_free_before", free_cnt, 10);
        cyc_a(2'd0, 2'd0);
        chk("wrap_ptr_after", rrftag1, 1);
        chk("wrap_free_after", free_cnt, 8);

        // Allocate tags 5,6; double writeback to 5; reallocate 5 under writeback.
        cyc_f(6'd5, 2'd0, 2'd0);
        cyc_a(2'd2, 2'd0);
        chk("wb_alloc_tag1", rrftag1, 5);
        chk("wb_alloc_tag2", rrftag2, 6);
        cyc(2'd0, 1'b0, 2'd0, 1'b1, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0);
        chk("wb_free", free_cnt, 2);
        cyc_a(2'd0, 2'd0);
        chk("wb_vld5_set", rrf_vld[5], 1);
        chk("wb_vld6_clear", rrf_vld[6], 0);
        cyc_f(6'd5, 2'd0, 2'd0);
        cyc(2'd1, 1'b0, 2'd0, 1'b1, 6'd5, 1'b1, 6'd40, 1'b0, 6'd0);
        chk("realloc_tag1", rrftag1, 5);
        cyc_a(2'd0, 2'd0);
        chk("realloc_vld5_clear", rrf_vld[5], 0);
        chk("realloc_vld40_set", rrf_vld[40], 1);

        // com_ptr=10, alloc_ptr=30, then flush to 20 with a commit and a suppressed request.
        cyc_a(2'd0, 2'd1);
        cyc_f(6'd30, 2'd0, 2'd0);
        cyc_f(6'd20, 2'd2, 2'd1);
        chk("pre_flush_tag1", rrftag1, 30);
        chk("pre_flush_com", com_ptr, 10);
        chk("pre_flush_free", free_cnt, 44);
        cyc_a(2'd0, 2'd0);
        chk("flush_tag1", rrftag1, 20);
        chk("flush_com", com_ptr, 11);
        chk("flush_free", free_cnt, 55);

        // Downstream stall holds the pointer; then rewind to 17 and reset asynchronously.
        cyc(2'd2, 1'b0, 2'd0, 1'b1, 6'd3, 1'b1, 6'd50, 1'b0, 6'd0);
        cyc(2'd1, 1'b1, 2'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        chk("stall_in_tag1", rrftag1, 22);
        cyc_f(6'd17, 2'd0, 2'd0);
        chk("stall_in_hold", rrftag1, 22);
        cyc_a(2'd0, 2'd0);
        chk("pre_rst_tag1", rrftag1, 17);
        chk("pre_rst_free", free_cnt, 58);
        chk("pre_rst_vld50", rrf_vld[50], 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tag1", rrftag1, 0);
        chk("async_rst_free", free_cnt, 64);
        chk("async_rst_vld", rrf_vld, 0);
        chk("async_rst_com", com_ptr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc_a(2'd1, 2'd0);
        chk("post_rst_tag1", rrftag1, 0);
        cyc_a(2'd0, 2'd0);
        chk("post_rst_next", rrftag1, 1);
        chk("post_rst_free", free_cnt, 63);
        cyc_a(2'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/rrf_alloc_ctrl.md
Name: rrf_alloc_ctrl

Overview:
- Allocation and retirement controller for the rename register file (RRF).
- Hands out up to two RRF tags per cycle, in order, to the rename stage. Frees tags in order as the ROB commits them, and rolls the allocation pointer back on a pipeline flush.
- Owns the per-entry RRF valid bits. Source-operand selection uses these bits to decide whether an operand is a value or a pending tag.

Parameters:
- RRF_ENT_SEL, 6, tag width; must equal `RRF_ENT_SEL from constants.vh.
- RRF_ENT_NUM, 64, number of RRF entries; must be 2**RRF_ENT_SEL.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_alloc_num  in  2  tags requested this cycle: 0, 1 or 2 (3 is illegal)
- i_stall_in  in  1  downstream stall; no allocation this cycle
- o_alloc_stall  out  1  combinational; asserted when i_alloc_num > o_free_cnt
- o_rrftag1  out  RRF_ENT_SEL  tag for slot 1; equals the allocation pointer
- o_rrftag2  out  RRF_ENT_SEL  tag for slot 2; equals (allocation pointer + 1) mod RRF_ENT_NUM
- i_com_num  in  2  tags retired this cycle: 0, 1 or 2
- i_wb1_en, i_wb2_en  in  1 each  writeback valid
- i_wb1_tag, i_wb2_tag  in  RRF_ENT_SEL each  writeback tags
- i_flush  in  1  misprediction recovery
- i_flush_ptr  in  RRF_ENT_SEL  first tag to discard on flush
- o_free_cnt  out  RRF_ENT_SEL+1  free entries, range 0..RRF_ENT_NUM
- o_com_ptr  out  RRF_ENT_SEL  oldest allocated tag
- o_rrf_vld  out  RRF_ENT_NUM  per-entry valid bit

Behaviour:
- Reset (async, i_rst=1): alloc_ptr=0, com_ptr=0, free_cnt=RRF_ENT_NUM, o_rrf_vld all zero.
- Allocation count:
  - alloc_eff = i_alloc_num when !i_stall_in && !o_alloc_stall && !i_flush; otherwise 0.
  - alloc_eff=1 consumes o_rrftag1 only; alloc_eff=2 consumes o_rrftag1 and o_rrftag2.
- Allocation update: alloc_ptr += alloc_eff, modulo RRF_ENT_NUM; wrap 63 -> 0 is natural.
- Allocated entries get o_rrf_vld cleared on the next edge.
- o_alloc_stall compares against the registered free_cnt only. Same-cycle commits do not relieve a stall; free space becomes visible the next cycle.
- Commit: com_ptr += i_com_num, modulo RRF_ENT_NUM. Valid bits of retired entries are not touched.
- Count update: free_cnt_next = free_cnt - alloc_eff + i_com_num. Allocate and commit in the same cycle are both applied.
- Writeback:
  - i_wbN_en sets o_rrf_vld[i_wbN_tag] on the next edge.
  - Both ports to the same tag is legal; the bit is set.
  - If a tag is allocated and written back in the same cycle, the allocate clear wins.
- Flush cycle:
  - Allocation is suppressed.
  - Commit in the same cycle is still applied.
  - alloc_ptr <- i_flush_ptr.
  - free_cnt_next = RRF_ENT_NUM - ((i_flush_ptr - com_ptr_next) mod RRF_ENT_NUM).
  - i_flush_ptr == com_ptr_next means every in-flight entry is discarded (free_cnt = RRF_ENT_NUM).
  - Valid bits are unchanged.
- Illegal inputs, with a simulation assertion for each; RRF state for these cases is not defined:
  - i_com_num exceeding the allocated count (RRF_ENT_NUM - free_cnt).
  - i_alloc_num == 3.
  - A flush that would discard nothing while the RRF is full.
- Tag outputs are combinational from the registered alloc_ptr, so valid in the request cycle; latency 0.
- Latency 1 for free_cnt and vld updates.
- Allocation is purely in order. No free list; the RRF is a ring.

Decomposition:
- Shared constants in constants.vh: `RRF_ENT_SEL, `RRF_ENT_NUM, plus a new `RRF_CNT_W (= `RRF_ENT_SEL+1).
- One natural sub-module, rrf_vld_array: owns the RRF_ENT_NUM valid flops, with two clear ports (alloc), two set ports (writeback) and clear priority.
- Pointer, count and stall logic stay in the top module.

Test Plan:
- Reset, then i_alloc_num=2 for 32 cycles, no commit.
  - Required: tags (0,1), (2,3) ... (62,63); free_cnt ends at 0.
  - Next request of 1: o_alloc_stall=1 and no pointer movement.
- Full RRF (free_cnt=0), i_alloc_num=1 with i_com_num=2 in the same cycle.
  - Required: stall=1 that cycle; next cycle free_cnt=2 and the allocation of tag 0 succeeds.
- Wrap case: alloc_ptr=63, free_cnt=10, i_alloc_num=2.
  - Required: o_rrftag1=63, o_rrftag2=0; next alloc_ptr=1, free_cnt=8.
- Tags 5 and 6 allocated; writeback i_wb1_tag=5 and i_wb2_tag=5 in the same cycle.
  - Required: o_rrf_vld[5]=1 next cycle, o_rrf_vld[6] stays 0.
  - Then re-allocate tag 5 while i_wb1_tag=5: o_rrf_vld[5]=0.
- com_ptr=10, alloc_ptr=30; i_flush=1, i_flush_ptr=20, i_com_num=1, i_alloc_num=2.
  - Required: no allocation; alloc_ptr=20, com_ptr=11, free_cnt=55.
- i_rst asserted mid-stream with alloc_ptr=17.
  - Required: outputs go to reset values immediately (async); o_rrftag1=0, free_cnt=64, o_rrf_vld all zero.
